// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with runtime divisor,
// optional parity and one or two stop bits.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 txd_q, txd_d;

  logic                 push, pop, nonempty;
  logic                 tick, last_stop;
  logic [DATA_BITS-1:0] head;
  logic [DIV_W-1:0]     div_eff;

  assign nonempty   = (count_q != '0);
  assign tx_ready   = (count_q < CW'(FIFO_DEPTH)) && reset_n;
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign div_eff    = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign tick       = (cnt_q == '0);
  assign last_stop  = !stop2_q || stop_idx_q;
  assign pop        = nonempty &&
                      ((state_q == IDLE) ||
                       ((state_q == STOP) && tick && last_stop));

  assign uart_txd   = txd_q;
  assign busy       = (state_q != IDLE) || nonempty;
  assign fifo_count = count_q;

  // FIFO storage; occupancy bookkeeping lives in the pointer block.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: bit timing, shifting, parity and stop handling.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;

    if (state_q != IDLE)
      cnt_d = tick ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (!last_stop) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    if (pop) begin
      state_d    = START;
      div_d      = div_eff;
      cnt_d      = div_eff - DIV_W'(1);
      bit_d      = '0;
      shreg_d    = head;
      par_en_d   = cfg_parity[0] ^ cfg_parity[1];
      par_bit_d  = (^head) ^ cfg_parity[1];
      stop2_d    = cfg_stop2;
      stop_idx_d = 1'b0;
      txd_d      = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
    end
  end

endmodule
